// File: rtl/fetch_pkg.sv
// Shared constants and the queue entry type for the instruction-fetch stage.
package fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order tagged fetch queue: entries are allocated at request time and
// filled by in-order memory responses; the head feeds the decode register.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_alloc,
    input  logic [XLEN-1:0]          i_alloc_pc,
    input  logic                     i_fill,
    input  logic [XLEN-1:0]          i_fill_instr,
    input  logic                     i_pop,
    input  logic                     i_clear,
    output fetch_entry_t             o_head,
    output logic [$clog2(DEPTH):0]   o_alloc_cnt,
    output logic [$clog2(DEPTH):0]   o_unfilled_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    fetch_entry_t entries_q [DEPTH];
    fetch_entry_t entries_d [DEPTH];

    logic [PW-1:0] head_ptr_q, head_ptr_d;
    logic [PW-1:0] tail_ptr_q, tail_ptr_d;
    logic [PW-1:0] fill_ptr_q, fill_ptr_d;
    logic [CW-1:0] alloc_cnt_q, alloc_cnt_d;
    logic [CW-1:0] unfilled_cnt_q, unfilled_cnt_d;

    logic alloc_ok;
    logic fill_ok;
    logic pop_ok;

    // fill_ptr always points at the oldest unfilled entry, so a response
    // arriving while the head is unfilled lands in the head (bypass case).
    always_comb begin
        entries_d      = entries_q;
        head_ptr_d     = head_ptr_q;
        tail_ptr_d     = tail_ptr_q;
        fill_ptr_d     = fill_ptr_q;
        alloc_cnt_d    = alloc_cnt_q;
        unfilled_cnt_d = unfilled_cnt_q;

        alloc_ok = i_alloc && (alloc_cnt_q < DEPTH_C);
        fill_ok  = i_fill && (unfilled_cnt_q != '0);
        pop_ok   = i_pop && (alloc_cnt_q != '0);

        if (i_clear) begin
            head_ptr_d     = '0;
            tail_ptr_d     = '0;
            fill_ptr_d     = '0;
            alloc_cnt_d    = '0;
            unfilled_cnt_d = '0;
        end else begin
            if (fill_ok) begin
                entries_d[fill_ptr_q].instr  = i_fill_instr;
                entries_d[fill_ptr_q].filled = 1'b1;
                fill_ptr_d = fill_ptr_q + PW'(1);
            end
            if (alloc_ok) begin
                entries_d[tail_ptr_q].pc     = i_alloc_pc;
                entries_d[tail_ptr_q].instr  = NOP_INSTR;
                entries_d[tail_ptr_q].filled = 1'b0;
                tail_ptr_d = tail_ptr_q + PW'(1);
            end
            if (pop_ok) begin
                head_ptr_d = head_ptr_q + PW'(1);
            end
            alloc_cnt_d    = alloc_cnt_q + CW'(alloc_ok) - CW'(pop_ok);
            unfilled_cnt_d = unfilled_cnt_q + CW'(alloc_ok) - CW'(fill_ok);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_ptr_q     <= '0;
            tail_ptr_q     <= '0;
            fill_ptr_q     <= '0;
            alloc_cnt_q    <= '0;
            unfilled_cnt_q <= '0;
        end else begin
            entries_q      <= entries_d;
            head_ptr_q     <= head_ptr_d;
            tail_ptr_q     <= tail_ptr_d;
            fill_ptr_q     <= fill_ptr_d;
            alloc_cnt_q    <= alloc_cnt_d;
            unfilled_cnt_q <= unfilled_cnt_d;
        end
    end

    assign o_head         = entries_q[head_ptr_q];
    assign o_alloc_cnt    = alloc_cnt_q;
    assign o_unfilled_cnt = unfilled_cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, in-order instruction-memory requests, squash of
// in-flight responses on redirect, and the fetch/decode pipeline register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_f_stall,
    input  logic        i_fd_stall,
    input  logic        i_fd_flush,
    input  logic        i_e_pc_src,
    input  logic [31:0] i_e_pc_target,
    output logic        o_imem_req_valid,
    input  logic        i_imem_req_ready,
    output logic [31:0] o_imem_req_addr,
    input  logic        i_imem_rsp_valid,
    input  logic [31:0] i_imem_rsp_data,
    output logic [31:0] o_d_instr,
    output logic [31:0] o_d_pc,
    output logic [31:0] o_d_pc_plus4,
    output logic        o_d_valid
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW:0] MAX_OCC = (CW + 1)'(QUEUE_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            d_valid_q, d_valid_d;
    logic [XLEN-1:0] d_instr_q, d_instr_d;
    logic [XLEN-1:0] d_pc_q, d_pc_d;
    logic [XLEN-1:0] d_pc_plus4_q, d_pc_plus4_d;

    fetch_entry_t  head;
    logic [CW-1:0] alloc_cnt;
    logic [CW-1:0] unfilled_cnt;
    logic [CW:0]   occupancy;

    logic req_hs;
    logic rsp_live;
    logic rsp_consumed;
    logic head_valid;
    logic pop;

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_alloc        (req_hs),
        .i_alloc_pc     (pc_q),
        .i_fill         (rsp_live),
        .i_fill_instr   (i_imem_rsp_data),
        .i_pop          (pop),
        .i_clear        (i_e_pc_src),
        .o_head         (head),
        .o_alloc_cnt    (alloc_cnt),
        .o_unfilled_cnt (unfilled_cnt)
    );

    // Request handshake: a transfer happens on a rising edge where valid and
    // ready are both high; valid never depends on ready.
    always_comb begin
        occupancy        = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q};
        o_imem_req_valid = i_rst_n && !i_f_stall && !i_e_pc_src && (occupancy < MAX_OCC);
        o_imem_req_addr  = pc_q;
        req_hs           = o_imem_req_valid && i_imem_req_ready;
        rsp_live         = i_imem_rsp_valid && (drop_cnt_q == '0);
        rsp_consumed     = i_imem_rsp_valid && ((drop_cnt_q != '0) || (unfilled_cnt != '0));
        head_valid       = (alloc_cnt != '0);
    end

    always_comb begin
        pc_d = pc_q;
        if (i_e_pc_src) begin
            pc_d = i_e_pc_target;
        end else if (req_hs) begin
            pc_d = pc_q + PC_STEP;
        end
    end

    // Every unfilled entry squashed by a redirect still owes a response,
    // which must be swallowed before any new response can be trusted.
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (i_e_pc_src) begin
            drop_cnt_d = drop_cnt_q + unfilled_cnt - CW'(rsp_consumed);
        end else if (i_imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end
    end

    always_comb begin
        d_valid_d    = d_valid_q;
        d_instr_d    = d_instr_q;
        d_pc_d       = d_pc_q;
        d_pc_plus4_d = d_pc_plus4_q;
        pop          = 1'b0;

        if (i_fd_flush) begin
            d_valid_d = 1'b0;
            d_instr_d = NOP_INSTR;
        end else if (!i_fd_stall) begin
            if (head_valid && head.filled) begin
                d_valid_d    = 1'b1;
                d_instr_d    = head.instr;
                d_pc_d       = head.pc;
                d_pc_plus4_d = head.pc + PC_STEP;
                pop          = 1'b1;
            end else if (head_valid && rsp_live) begin
                d_valid_d    = 1'b1;
                d_instr_d    = i_imem_rsp_data;
                d_pc_d       = head.pc;
                d_pc_plus4_d = head.pc + PC_STEP;
                pop          = 1'b1;
            end else begin
                d_valid_d = 1'b0;
                d_instr_d = NOP_INSTR;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            pc_q         <= RESET_PC;
            drop_cnt_q   <= '0;
            d_valid_q    <= 1'b0;
            d_instr_q    <= NOP_INSTR;
            d_pc_q       <= '0;
            d_pc_plus4_q <= '0;
        end else begin
            pc_q         <= pc_d;
            drop_cnt_q   <= drop_cnt_d;
            d_valid_q    <= d_valid_d;
            d_instr_q    <= d_instr_d;
            d_pc_q       <= d_pc_d;
            d_pc_plus4_q <= d_pc_plus4_d;
        end
    end

    assign o_d_valid    = d_valid_q;
    assign o_d_instr    = d_instr_q;
    assign o_d_pc       = d_pc_q;
    assign o_d_pc_plus4 = d_pc_plus4_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: variable-latency in-order memory model, decode
// scoreboard fed at request handshake, and one task per scenario.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_f_stall, i_fd_stall, i_fd_flush, i_e_pc_src;
    logic [31:0] i_e_pc_target;
    logic        o_imem_req_valid, i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic [31:0] o_d_instr, o_d_pc, o_d_pc_plus4;
    logic        o_d_valid;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] exp_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC   (32'h0000_0000),
        .QUEUE_DEPTH(2)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (i_rst_n),
        .i_f_stall       (i_f_stall),
        .i_fd_stall      (i_fd_stall),
        .i_fd_flush      (i_fd_flush),
        .i_e_pc_src      (i_e_pc_src),
        .i_e_pc_target   (i_e_pc_target),
        .o_imem_req_valid(o_imem_req_valid),
        .i_imem_req_ready(i_imem_req_ready),
        .o_imem_req_addr (o_imem_req_addr),
        .i_imem_rsp_valid(i_imem_rsp_valid),
        .i_imem_rsp_data (i_imem_rsp_data),
        .o_d_instr       (o_d_instr),
        .o_d_pc          (o_d_pc),
        .o_d_pc_plus4    (o_d_pc_plus4),
        .o_d_valid       (o_d_valid)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory model: in-order responses `lat` cycles after the handshake cycle.
    initial begin
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (i_rst_n && o_imem_req_valid && i_imem_req_ready) begin
                pend_addr.push_back(o_imem_req_addr);
                pend_due.push_back(cyc + lat);
                exp_q.push_back(o_imem_req_addr);
            end
            step();
            if (i_imem_rsp_valid) begin
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end
            cyc++;
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                i_imem_rsp_valid = 1'b1;
                i_imem_rsp_data  = mem_word(pend_addr[0]);
            end else begin
                i_imem_rsp_valid = 1'b0;
                i_imem_rsp_data  = 32'hDEAD_BEEF;
            end
        end
    end

    // Scoreboard: each newly loaded decode entry must be the oldest expected pc.
    initial begin
        logic        held;
        logic [31:0] exp_pc;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (i_rst_n) begin
                checks++;
                if (int'(dut.alloc_cnt) + int'(dut.drop_cnt_q) > 2) begin
                    errors++;
                    $display("FAIL occupancy: alloc=%0d drop=%0d limit=2", dut.alloc_cnt, dut.drop_cnt_q);
                end
                if (o_d_valid && !held) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_unexpected: pc=%h instr=%h with nothing expected", o_d_pc, o_d_instr);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        if (o_d_pc !== exp_pc || o_d_instr !== mem_word(exp_pc) || o_d_pc_plus4 !== exp_pc + 32'd4) begin
                            errors++;
                            $display("FAIL sb_decode: pc=%h instr=%h pc4=%h expected pc=%h instr=%h pc4=%h",
                                     o_d_pc, o_d_instr, o_d_pc_plus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
                        end
                    end
                end
            end
            held = i_fd_stall && !i_fd_flush && i_rst_n;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic do_reset(input int new_lat);
        i_f_stall = 1'b1; i_fd_stall = 1'b0; i_fd_flush = 1'b0;
        i_e_pc_src = 1'b0; i_imem_req_ready = 1'b1;
        repeat (8) step();
        i_rst_n = 1'b0;
        repeat (2) step();
        exp_q.delete();
        lat = new_lat;
        i_f_stall = 1'b0;
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_f_stall = 1'b0; i_fd_stall = 1'b0; i_fd_flush = 1'b0;
        i_e_pc_src = 1'b0; i_e_pc_target = '0; i_imem_req_ready = 1'b1; lat = 1;
        repeat (2) step();
        @(negedge clk);
        checks++; if (o_d_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_d_valid); end
        checks++; if (o_d_instr !== NOP) begin errors++; $display("FAIL rst_instr: got %h want %h", o_d_instr, NOP); end
        checks++; if (o_d_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 0", o_d_pc); end
        checks++; if (o_d_pc_plus4 !== 32'h0) begin errors++; $display("FAIL rst_pc4: got %h want 0", o_d_pc_plus4); end
        checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", o_imem_req_valid); end
        step();
    endtask

    task automatic test_stream();
        do_reset(1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'(4 * k)) begin
                errors++;
                $display("FAIL stream_req: cycle %0d valid=%b addr=%h want 1/%h", k, o_imem_req_valid, o_imem_req_addr, 32'(4 * k));
            end
            checks++;
            if (k >= 2) begin
                if (o_d_valid !== 1'b1 || o_d_pc !== 32'(4 * (k - 2)) || o_d_pc_plus4 !== 32'(4 * (k - 1))) begin
                    errors++;
                    $display("FAIL stream_dec: cycle %0d valid=%b pc=%h pc4=%h want 1/%h/%h",
                             k, o_d_valid, o_d_pc, o_d_pc_plus4, 32'(4 * (k - 2)), 32'(4 * (k - 1)));
                end
            end else if (o_d_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_bubble: cycle %0d valid=%b want 0", k, o_d_valid);
            end
            step();
        end
    endtask

    task automatic test_fd_stall();
        do_reset(1);
        repeat (4) step();
        i_fd_stall = 1'b1;
        for (int k = 4; k < 8; k++) begin
            if (k == 7) i_fd_stall = 1'b0;
            @(negedge clk);
            checks++;
            if (o_d_valid !== 1'b1 || o_d_pc !== 32'h8) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d valid=%b pc=%h want 1/00000008", k, o_d_valid, o_d_pc);
            end
            if (k == 5 || k == 6) begin
                checks++;
                if (o_imem_req_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_issue: cycle %0d req_valid=%b want 0", k, o_imem_req_valid);
                end
            end
            if (k == 6) begin
                checks++;
                if (dut.alloc_cnt !== 2'd2) begin
                    errors++;
                    $display("FAIL stall_full: alloc_cnt=%0d want 2", dut.alloc_cnt);
                end
            end
            step();
        end
        for (int k = 8; k < 11; k++) begin
            @(negedge clk);
            checks++;
            if (o_d_valid !== 1'b1 || o_d_pc !== 32'(4 * k - 20)) begin
                errors++;
                $display("FAIL stall_resume: cycle %0d valid=%b pc=%h want 1/%h", k, o_d_valid, o_d_pc, 32'(4 * k - 20));
            end
            step();
        end
    endtask

    task automatic test_redirect();
        logic found;
        do_reset(3);
        repeat (2) step();
        i_e_pc_src = 1'b1; i_e_pc_target = 32'h100; i_fd_flush = 1'b1;
        @(negedge clk);
        checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_noissue: got %b want 0", o_imem_req_valid); end
        step();
        exp_q.delete();
        i_e_pc_src = 1'b0; i_fd_flush = 1'b0;
        @(negedge clk);
        checks++; if (dut.drop_cnt_q !== 2'd2) begin errors++; $display("FAIL redir_drop2: got %0d want 2", dut.drop_cnt_q); end
        checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL redir_occ: req_valid=%b want 0", o_imem_req_valid); end
        step();
        @(negedge clk);
        checks++;
        if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h100) begin
            errors++;
            $display("FAIL redir_req: valid=%b addr=%h want 1/00000100", o_imem_req_valid, o_imem_req_addr);
        end
        step();
        @(negedge clk);
        checks++; if (dut.drop_cnt_q !== 2'd0) begin errors++; $display("FAIL redir_drop0: got %0d want 0", dut.drop_cnt_q); end
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (o_d_valid === 1'b1) begin
                found = 1'b1;
                checks++;
                if (o_d_pc !== 32'h100 || o_d_instr !== mem_word(32'h100)) begin
                    errors++;
                    $display("FAIL redir_first: pc=%h instr=%h want 00000100/%h", o_d_pc, o_d_instr, mem_word(32'h100));
                end
            end else begin
                step();
                @(negedge clk);
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL redir_timeout: no valid decode within 10 cycles");
        end
    endtask

    task automatic test_flush();
        do_reset(1);
        repeat (10) step();
        i_fd_flush = 1'b1;
        @(negedge clk);
        checks++; if (o_d_valid !== 1'b1 || o_d_pc !== 32'h20) begin errors++; $display("FAIL flush_pre: valid=%b pc=%h want 1/00000020", o_d_valid, o_d_pc); end
        step();
        i_fd_flush = 1'b0;
        @(negedge clk);
        checks++; if (o_d_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", o_d_valid); end
        checks++; if (o_d_instr !== NOP) begin errors++; $display("FAIL flush_instr: got %h want %h", o_d_instr, NOP); end
        step();
        @(negedge clk);
        checks++; if (o_d_valid !== 1'b1 || o_d_pc !== 32'h24) begin errors++; $display("FAIL flush_next: valid=%b pc=%h want 1/00000024", o_d_valid, o_d_pc); end
    endtask

    task automatic test_ready_low();
        do_reset(1);
        i_imem_req_ready = 1'b0;
        for (int k = 0; k < 7; k++) begin
            if (k == 4) i_imem_req_ready = 1'b1;
            @(negedge clk);
            if (k < 4) begin
                checks++;
                if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL ready_hold: cycle %0d valid=%b addr=%h want 1/00000000", k, o_imem_req_valid, o_imem_req_addr);
                end
            end
            checks++;
            if (k < 6 && o_d_valid !== 1'b0) begin
                errors++;
                $display("FAIL ready_bubble: cycle %0d valid=%b want 0", k, o_d_valid);
            end else if (k == 6 && (o_d_valid !== 1'b1 || o_d_pc !== 32'h0)) begin
                errors++;
                $display("FAIL ready_first: valid=%b pc=%h want 1/00000000", o_d_valid, o_d_pc);
            end
            step();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset(2);
        repeat (4) step();
        i_f_stall = 1'b1;
        i_rst_n   = 1'b0;
        @(negedge clk);
        checks++; if (o_imem_req_valid !== 1'b0) begin errors++; $display("FAIL mid_req_rst: got %b want 0", o_imem_req_valid); end
        step();
        exp_q.delete();
        i_rst_n   = 1'b1;
        i_f_stall = 1'b0;
        for (int k = 5; k < 9; k++) begin
            @(negedge clk);
            if (k == 5) begin
                checks++;
                if (o_imem_req_valid !== 1'b1 || o_imem_req_addr !== 32'h0) begin
                    errors++;
                    $display("FAIL mid_restart: valid=%b addr=%h want 1/00000000", o_imem_req_valid, o_imem_req_addr);
                end
            end
            checks++;
            if (k < 8 && o_d_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_bubble: cycle %0d valid=%b pc=%h want 0", k, o_d_valid, o_d_pc);
            end else if (k == 8 && (o_d_valid !== 1'b1 || o_d_pc !== 32'h0 || o_d_instr !== mem_word(32'h0))) begin
                errors++;
                $display("FAIL mid_first: valid=%b pc=%h instr=%h want 1/00000000/%h", o_d_valid, o_d_pc, o_d_instr, mem_word(32'h0));
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_fd_stall();
        test_redirect();
        test_flush();
        test_ready_low();
        test_reset_midstream();
        repeat (4) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus the fetch/decode pipeline register of the RV32I pipelined core.
- Owns the PC and issues in-order requests to a latency-variable instruction memory through a valid/ready handshake.
- Buffers returned instructions in a small tagged queue and loads the decode register.
- Obeys the hazard unit's F-stall, FD-stall and FD-flush, and the execute-stage branch redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- QUEUE_DEPTH, 2, maximum instructions allocated plus in flight (power of 2, at least 2).

Ports:
- i_clk  in  1  single clock; all state updates on the rising edge.
- i_rst_n  in  1  reset; synchronous, active-low.
- i_f_stall  in  1  hazard unit: hold PC, issue no new request.
- i_fd_stall  in  1  hazard unit: hold the decode register.
- i_fd_flush  in  1  hazard unit: load a bubble into the decode register.
- i_e_pc_src  in  1  execute stage: redirect taken.
- i_e_pc_target  in  32  execute stage: redirect target.
- o_imem_req_valid  out  1  fetch request valid.
- i_imem_req_ready  in  1  memory accepts the request.
- o_imem_req_addr  out  32  request address (current PC).
- i_imem_rsp_valid  in  1  response valid; responses return in order, latency at least 1.
- i_imem_rsp_data  in  32  instruction word.
- o_d_instr  out  32  decode-register instruction.
- o_d_pc  out  32  decode-register PC.
- o_d_pc_plus4  out  32  decode-register PC+4.
- o_d_valid  out  1  decode register holds a real instruction.

Behaviour:
- Reset (i_rst_n low at an edge):
  - PC is set to RESET_PC; the queue is emptied; drop_cnt is cleared.
  - o_d_valid=0, o_d_instr=NOP (32'h0000_0013), o_d_pc=0, o_d_pc_plus4=0.
  - o_imem_req_valid is forced to 0 while i_rst_n is low.
  - Reset mid-operation discards all state. Any response arriving while nothing is allocated and drop_cnt=0 is ignored.
- Queue:
  - Circular buffer of QUEUE_DEPTH entries, each holding {pc, instr, filled}.
  - An entry is allocated at request handshake (pc recorded, filled=0).
  - The oldest unfilled entry is filled on i_imem_rsp_valid when drop_cnt=0.
- Issue:
  - o_imem_req_valid = !i_f_stall & !i_e_pc_src & (alloc_cnt + drop_cnt < QUEUE_DEPTH).
  - o_imem_req_addr = PC.
  - On handshake, PC advances by 4 (32-bit wrap-around, no trap). PC is otherwise held.
- Redirect (i_e_pc_src=1):
  - PC is set to i_e_pc_target.
  - All allocated entries are cleared.
  - drop_cnt is set to drop_cnt + (number of unfilled allocated entries) - (1 if a response arrives this cycle).
  - While drop_cnt>0, each response is discarded and decrements drop_cnt.
  - Redirect has priority over i_f_stall. No request is issued in the redirect cycle.
- Decode register, priority order:
  1. i_fd_flush: o_d_valid=0, o_d_instr=NOP, PC fields don't-care (hold).
  2. i_fd_stall: all outputs hold.
  3. Otherwise, load the head entry if it is filled (pop it).
  4. Otherwise, bypass: if the head is allocated, unfilled, and a non-dropped response arrives this cycle, load that data with the head pc and pop.
  5. Otherwise, load a bubble (valid=0, NOP).
  - o_d_pc_plus4 is loaded as entry pc + 4.
- Latency: with a 1-cycle memory and no stalls, a request issued in cycle N appears in the decode register after edge N+2 (bypass path). Throughput is 1 instruction per cycle.
- Boundaries:
  - Queue full: issue stops; a pop and an issue in the same cycle are both allowed.
  - Queue empty: the decode register receives bubbles.
  - Flush in the same cycle as a redirect: both are applied.
  - FD-stall while a response arrives: the response fills the queue and is not lost.
  - Simultaneous pop, fill and allocate in one cycle are all legal.
- Counters: alloc_cnt and drop_cnt are each clog2(QUEUE_DEPTH)+1 bits. alloc_cnt + drop_cnt never exceeds QUEUE_DEPTH; the bench asserts this.

Decomposition:
- Package fetch_pkg holds:
  - XLEN=32.
  - NOP_INSTR=32'h0000_0013.
  - PC_STEP=4.
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] instr; logic filled;}.
- Sub-module fetch_queue:
  - Circular buffer with allocate, fill, pop and clear.
  - Exposes head entry, alloc_cnt and unfilled_cnt.
- fetch_stage contains the PC, issue logic, drop counter and decode register.

Test Plan:
- Reset with RESET_PC=0, 1-cycle memory, no stalls -> addresses 0,4,8 issued on consecutive cycles; o_d_pc 0,4,8 with o_d_valid=1 from the third edge onward; o_d_pc_plus4 4,8,12.
- i_fd_stall high for 3 cycles with the decode register at pc 8 -> outputs hold 8; queue fills to 2; issue stops; after release, pcs 12 and 16 follow with no bubble.
- 3-cycle memory latency, redirect to 0x100 with 2 requests outstanding -> both late responses are dropped (drop_cnt 2 -> 0); first valid decode pc is 0x100; no stale instruction appears.
- i_fd_flush with the decode register at pc 0x20 -> next cycle o_d_valid=0, o_d_instr=0x00000013.
- i_imem_req_ready=0 for 4 cycles -> PC holds; o_d_valid=0 bubbles for 4 cycles.
- i_rst_n low mid-stream with 1 request outstanding -> after reset, the stray response is ignored; fetch restarts at RESET_PC; o_d_valid=0 until the first new response.
